// File: rtl/decoder_seq_pkg.sv
// decoder_seq_pkg
//   Shared definitions for the sequenced one-hot decoder: the load-time
//   mode codes and the controller state encoding.
package decoder_seq_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_PULSE  = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DIRECT = 2'b01,
    ST_SCAN   = 2'b10,
    ST_PULSE  = 2'b11
  } state_t;

endpackage

// File: rtl/decoder_seq_onehot_dec.sv
// onehot_dec
//   Purely combinational index -> one-hot decoder.
//   Ports:
//     idx  in  SEL_W  channel index
//     out  out OUT_N  one-hot of idx; all zero when idx >= OUT_N
module onehot_dec #(
  parameter int SEL_W = 3,
  parameter int OUT_N = 8
) (
  input  logic [SEL_W-1:0] idx,
  output logic [OUT_N-1:0] out
);

  // An index past the last channel matches no bit, so it decodes to zero.
  for (genvar gi = 0; gi < OUT_N; gi++) begin : g_bit
    assign out[gi] = (idx == SEL_W'(gi));
  end

endmodule

// File: rtl/decoder_seq.sv
// decoder_seq
//   Registered one-hot channel selector with three load-selected modes:
//   direct (follows live sel), scan (rotates channels with a dwell time)
//   and pulse (one channel for dwell+1 cycles, then idle).
//   Ports:
//     clk         in   rising-edge clock
//     rst_n       in   asynchronous active-low reset
//     en          in   global enable; low forces idle with outputs cleared
//     load        in   strobe capturing mode/sel/dwell and starting work
//     mode        in   00 direct, 01 scan, 10 pulse, 11 reserved (idle)
//     sel         in   channel index (direct) or start index (scan/pulse)
//     dwell       in   scan cycles per channel / pulse length, minus one
//     out         out  registered one-hot channel select
//     active_idx  out  index of the asserted out bit, 0 when out is zero
//     busy        out  high while scanning or pulsing
//     wrap        out  one-cycle flag when scan moves from OUT_N-1 to 0
module decoder_seq
  import decoder_seq_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int OUT_N   = 8,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               load,
  input  logic [1:0]         mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_N-1:0]   out,
  output logic [SEL_W-1:0]   active_idx,
  output logic               busy,
  output logic               wrap
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_N - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_cap_q, dwell_cap_d;
  logic [OUT_N-1:0]   out_q, out_d;
  logic [SEL_W-1:0]   active_idx_q, active_idx_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;

  logic [SEL_W-1:0]   dec_idx;
  logic               dec_on;
  logic [OUT_N-1:0]   dec_out;
  logic               sel_in_range;
  logic [SEL_W-1:0]   next_idx;

  onehot_dec #(
    .SEL_W (SEL_W),
    .OUT_N (OUT_N)
  ) u_dec (
    .idx (dec_idx),
    .out (dec_out)
  );

  // Widen by one bit so OUT_N == 2**SEL_W compares correctly.
  assign sel_in_range = ({1'b0, sel} < (SEL_W + 1)'(OUT_N));
  assign next_idx     = (idx_q == LAST_IDX) ? '0 : idx_q + SEL_W'(1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    dwell_cap_d = dwell_cap_q;
    wrap_d      = 1'b0;
    dec_idx     = idx_q;
    dec_on      = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (load) begin
      dwell_cap_d = dwell;
      cnt_d       = '0;
      case (mode)
        MODE_DIRECT: state_d = ST_DIRECT;
        MODE_SCAN: begin
          state_d = ST_SCAN;
          idx_d   = sel_in_range ? sel : '0;
        end
        MODE_PULSE: begin
          // An unreachable channel makes the pulse a no-op.
          if (sel_in_range) begin
            state_d = ST_PULSE;
            idx_d   = sel;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      case (state_q)
        ST_SCAN: begin
          if (cnt_q == dwell_cap_q) begin
            cnt_d  = '0;
            idx_d  = next_idx;
            wrap_d = (idx_q == LAST_IDX);
          end else begin
            cnt_d = cnt_q + DWELL_W'(1);
          end
        end
        ST_PULSE: begin
          // cnt_q == dwell_cap_q marks the last of dwell+1 asserted cycles.
          if (cnt_q == dwell_cap_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + DWELL_W'(1);
          end
        end
        default: ;
      endcase
    end

    // Outputs are decoded from the next state so they land on the same edge.
    case (state_d)
      ST_DIRECT: begin
        dec_idx = sel;
        dec_on  = 1'b1;
      end
      ST_SCAN, ST_PULSE: begin
        dec_idx = idx_d;
        dec_on  = 1'b1;
      end
      default: ;
    endcase

    out_d        = dec_on ? dec_out : '0;
    active_idx_d = (out_d != '0) ? dec_idx : '0;
    busy_d       = (state_d == ST_SCAN) || (state_d == ST_PULSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      dwell_cap_q  <= '0;
      out_q        <= '0;
      active_idx_q <= '0;
      busy_q       <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      dwell_cap_q  <= dwell_cap_d;
      out_q        <= out_d;
      active_idx_q <= active_idx_d;
      busy_q       <= busy_d;
      wrap_q       <= wrap_d;
    end
  end

  assign out        = out_q;
  assign active_idx = active_idx_q;
  assign busy       = busy_q;
  assign wrap       = wrap_q;

endmodule
